// File: rtl/mem_sp_pipe.sv
// mem_sp_pipe: single-port word RAM with byte-enable writes, an RD_LAT-deep
// read pipeline with rvalid, out-of-range detection, and a self-initialising
// sweep that writes INIT_VAL to every word after reset.
//
// Ports
//   clk        clock, all logic on posedge
//   reset      asynchronous active-low reset
//   addr       word address of the request
//   wr_en      write request
//   rd_en      read request
//   wdata      write data
//   be         byte enables, be[i] gates wdata[8i+7:8i]
//   req_ready  requests are accepted this cycle (high once the sweep is done)
//   rdata      read data, valid with rvalid, held otherwise
//   rvalid     one-cycle pulse per accepted read, RD_LAT cycles after acceptance
//   rerr       with rvalid: the read address was out of range (rdata = 0)
//   werr       one-cycle pulse after an accepted out-of-range write
module mem_sp_pipe #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  req_ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  rerr,
  output logic                  werr
);

  localparam int unsigned      BE_W     = DATA_W / 8;
  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               ready;
  logic               in_range;
  logic               acc_wr;
  logic               acc_rd;
  logic [IDX_W-1:0]   idx;

  logic               pv_q [RD_LAT];
  logic               pe_q [RD_LAT];
  logic [DATA_W-1:0]  pd_q [RD_LAT];

  logic               rvalid_q;
  logic               rerr_q;
  logic               werr_q;
  logic [DATA_W-1:0]  rdata_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == S_INIT) begin
      if (init_cnt_q == LAST_IDX) begin
        state_d = S_READY;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ready     = (state_q == S_READY);
    in_range  = ({1'b0, addr} < DEPTH_X);
    idx       = addr[IDX_W-1:0];
    acc_wr    = ready & wr_en;
    acc_rd    = ready & rd_en;
    req_ready = ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Array is never reset; the sweep overwrites it. Out-of-range writes are
  // dropped rather than folded onto the truncated index.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[init_cnt_q] <= INIT_VAL;
    end else if (acc_wr && in_range) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage 0 samples the array before this edge's write lands, giving
  // read-first behaviour for a simultaneous read and write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= 1'b0;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= acc_rd;
      pe_q[0] <= acc_rd & ~in_range;
      pd_q[0] <= (acc_rd && in_range) ? mem_q[idx] : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      werr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pv_q[RD_LAT-1];
      rerr_q   <= pe_q[RD_LAT-1];
      werr_q   <= acc_wr & ~in_range;
      if (pv_q[RD_LAT-1]) rdata_q <= pd_q[RD_LAT-1];
    end
  end

  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
  assign werr   = werr_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_sp_pipe.sv
module tb_mem_sp_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=16, RD_LAT=3, INIT_VAL=0
  logic [15:0] a_addr = '0;
  logic        a_wr = 1'b0, a_rd = 1'b0;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_be = '0;
  logic        a_rdy, a_rvalid, a_rerr, a_werr;
  logic [31:0] a_rdata;

  // Instance B: DEPTH=1000, RD_LAT=1, INIT_VAL=A5A50F0F
  logic [15:0] b_addr = '0;
  logic        b_wr = 1'b0, b_rd = 1'b0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic        b_rdy, b_rvalid, b_rerr, b_werr;
  logic [31:0] b_rdata;

  mem_sp_pipe #(.ADDR_W(16), .DATA_W(32), .DEPTH(16), .RD_LAT(3),
                .INIT_VAL(32'h0000_0000)) u_a (
    .clk(clk), .reset(rst_n), .addr(a_addr), .wr_en(a_wr), .rd_en(a_rd),
    .wdata(a_wdata), .be(a_be), .req_ready(a_rdy), .rdata(a_rdata),
    .rvalid(a_rvalid), .rerr(a_rerr), .werr(a_werr));

  mem_sp_pipe #(.ADDR_W(16), .DATA_W(32), .DEPTH(1000), .RD_LAT(1),
                .INIT_VAL(32'hA5A5_0F0F)) u_b (
    .clk(clk), .reset(rst_n), .addr(b_addr), .wr_en(b_wr), .rd_en(b_rd),
    .wdata(b_wdata), .be(b_be), .req_ready(b_rdy), .rdata(b_rdata),
    .rvalid(b_rvalid), .rerr(b_rerr), .werr(b_werr));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_werr;
    logic        exp_rvalid;
    logic        exp_rerr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic a_write(input logic [15:0] ad, input logic [31:0] wd, input logic [3:0] bm);
    a_addr = ad; a_wdata = wd; a_be = bm; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic a_wait_rvalid(input string nm, input logic [31:0] exp);
    int lat = 0;
    while (!a_rvalid && lat < 10) begin
      tick();
      lat++;
    end
    chk({nm, "_lat"}, lat, 3);
    chk(nm, a_rdata, exp);
  endtask

  task automatic a_read(input logic [15:0] ad, input logic [31:0] exp, input string nm);
    a_addr = ad; a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    a_wait_rvalid(nm, exp);
  endtask

  initial begin
    int na, nb, n;
    logic seen;

    vt[0]  = '{1'b0, 1'b1, 16'd0,     32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F};
    vt[1]  = '{1'b0, 1'b1, 16'd999,   32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F};
    vt[2]  = '{1'b1, 1'b0, 16'd1000,  32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 16'd1000,  32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 16'd999,   32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F};
    vt[5]  = '{1'b1, 1'b0, 16'd3,     32'h1122_3344, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 16'd3,     32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 16'd3,     32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'h11BB_33DD};
    vt[8]  = '{1'b1, 1'b0, 16'd1027,  32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 16'd3,     32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'h11BB_33DD};
    vt[10] = '{1'b1, 1'b0, 16'd4,     32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[11] = '{1'b0, 1'b1, 16'd4,     32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F};
    vt[12] = '{1'b0, 1'b1, 16'd65535, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 32'h0};
    vt[13] = '{1'b1, 1'b1, 16'd0,     32'h5A5A_5A5A, 4'hF, 1'b0, 1'b1, 1'b0, 32'hA5A5_0F0F};
    vt[14] = '{1'b0, 1'b1, 16'd0,     32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'h5A5A_5A5A};
    vt[15] = '{1'b1, 1'b0, 16'd999,   32'h0102_0304, 4'hA, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[16] = '{1'b0, 1'b1, 16'd999,   32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 32'h01A5_030F};
    vt[17] = '{1'b1, 1'b0, 16'd1023,  32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};

    // Reset values
    tick();
    tick();
    chk("rst_ready", a_rdy, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_rerr", a_rerr, 0);
    chk("rst_werr", a_werr, 0);
    chk("rst_b_ready", b_rdy, 0);

    // Init sweep length
    rst_n = 1'b1;
    na = 0;
    nb = 0;
    for (int c = 1; c <= 1100; c++) begin
      tick();
      if (na == 0 && a_rdy) na = c;
      if (nb == 0 && b_rdy) nb = c;
      if (na != 0 && nb != 0) break;
    end
    chk("init_cycles_a", na, 16);
    chk("init_cycles_b", nb, 1000);

    // Every word of A holds INIT_VAL
    for (int i = 0; i < 16; i++) a_read(16'(i), 32'h0, $sformatf("init_rd%0d", i));

    // RD_LAT=3 write then read, read one cycle after write
    a_write(16'd5, 32'hDEAD_BEEF, 4'hF);
    a_read(16'd5, 32'hDEAD_BEEF, "wr_rd5");
    a_write(16'd8, 32'h0000_0088, 4'hF);
    a_read(16'd8, 32'h0000_0088, "raw8");

    // rvalid is a single-cycle pulse and rdata holds
    tick();
    chk("pulse_rvalid", a_rvalid, 0);
    chk("hold_rdata", a_rdata, 32'h0000_0088);

    // Simultaneous write and read: read-first
    a_addr = 16'd7; a_wdata = 32'h5A5A_5A5A; a_be = 4'hF; a_wr = 1'b1; a_rd = 1'b1;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    a_wait_rvalid("rw_same_old", 32'h0);
    a_read(16'd7, 32'h5A5A_5A5A, "rw_same_new");

    // Back-to-back reads return in order on consecutive cycles
    a_write(16'd9, 32'h0000_0099, 4'hF);
    a_rd = 1'b1; a_addr = 16'd5;
    tick();
    a_addr = 16'd8;
    tick();
    a_addr = 16'd9;
    tick();
    a_rd = 1'b0;
    tick();
    chk("b2b0_v", a_rvalid, 1); chk("b2b0_d", a_rdata, 32'hDEAD_BEEF);
    tick();
    chk("b2b1_v", a_rvalid, 1); chk("b2b1_d", a_rdata, 32'h0000_0088);
    tick();
    chk("b2b2_v", a_rvalid, 1); chk("b2b2_d", a_rdata, 32'h0000_0099);
    tick();
    chk("b2b_end_v", a_rvalid, 0);

    // Table-driven vectors on B (RD_LAT=1)
    for (int i = 0; i < 18; i++) begin
      b_addr = vt[i].addr; b_wdata = vt[i].wdata; b_be = vt[i].be;
      b_wr = vt[i].wr; b_rd = vt[i].rd;
      tick();
      b_wr = 1'b0; b_rd = 1'b0;
      chk($sformatf("vec%0d_werr", i), b_werr, vt[i].exp_werr);
      tick();
      chk($sformatf("vec%0d_werr_clr", i), b_werr, 0);
      chk($sformatf("vec%0d_rvalid", i), b_rvalid, vt[i].exp_rvalid);
      chk($sformatf("vec%0d_rerr", i), b_rerr, vt[i].exp_rerr);
      if (vt[i].exp_rvalid) chk($sformatf("vec%0d_rdata", i), b_rdata, vt[i].exp_rdata);
    end

    // Reset mid-pipeline: in-flight reads dropped, sweep restarts
    a_write(16'd2, 32'h0000_0077, 4'hF);
    a_rd = 1'b1; a_addr = 16'd2;
    tick();
    a_addr = 16'd3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", a_rvalid, 0);
    chk("midrst_ready", a_rdy, 0);
    chk("midrst_rdata", a_rdata, 0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen = seen | a_rvalid;
    end
    rst_n = 1'b1;
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      seen = seen | a_rvalid | a_werr;
      if (a_rdy) begin
        n = c;
        break;
      end
    end
    a_rd = 1'b0;
    chk("rerst_init_cycles", n, 16);
    chk("rerst_no_rvalid", seen, 0);
    tick();
    tick();
    tick();
    tick();
    a_read(16'd2, 32'h0, "rerst_overwritten");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
